// File: rtl/sm_board_ctrl.sv
// sm_board_ctrl: board key debounce, core clock-enable generation (RUN divider
// or STEP presses) and paged register display on an LED bank.
// Optional feature macro: SM_BOARD_STEP_EN compiles in the RUN/STEP mode FSM
// and the step key; without it the core always runs from the divider.

// Two-flop synchronizer plus debounce; emits a one-cycle pulse on a press.
module sm_board_debounce #(
    parameter int CYCLES = 50000
) (
    input  logic clkIn,
    input  logic rst_n,
    input  logic key_n,
    output logic press
);
    localparam int CW = $clog2(CYCLES + 1);

    logic          s1;
    logic          s2;
    logic          stable;
    logic [CW-1:0] cnt;

    // Accept a new level only after CYCLES consecutive mismatching samples.
    always_ff @(posedge clkIn) begin
        if (!rst_n) begin
            s1     <= 1'b1;
            s2     <= 1'b1;
            stable <= 1'b1;
            cnt    <= '0;
            press  <= 1'b0;
        end else begin
            s1    <= key_n;
            s2    <= s1;
            press <= 1'b0;
            if (s2 != stable) begin
                if (cnt == CW'(CYCLES - 1)) begin
                    stable <= s2;
                    cnt    <= '0;
                    press  <= ~s2;  // only the 1->0 transition is a press
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end
endmodule

module sm_board_ctrl #(
    parameter int LED_W           = 8,
    parameter int SW_W            = 4,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic             clkIn,
    input  logic             rst_n,
    input  logic             keyMode_n,
    input  logic             keyStep_n,
    input  logic             keyPage_n,
    input  logic [SW_W-1:0]  sw,
    input  logic [3:0]       clkDivide,
    input  logic [31:0]      regData,
    output logic [4:0]       regAddr,
    output logic             cpuClkEn,
    output logic             running,
    output logic [LED_W-1:0] led
);
    localparam int PAGES = (32 + LED_W - 2) / (LED_W - 1);
    localparam int PW    = (PAGES > 1) ? $clog2(PAGES) : 1;
    localparam int WW    = 32 + LED_W - 1;

    logic            page_press;
    logic            mode_press;
    logic            run_entry;
    logic            step_fire;
    logic [15:0]     cnt;
    logic [15:0]     mask;
    logic            en_next;
    logic            hb;
    logic [PW-1:0]   page;
    logic [SW_W-1:0] sw_s1;
    logic [LED_W-2:0] led_hi;
    logic [15:0]     shamt;
    logic [WW-1:0]   shifted;

    sm_board_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_page_key (
        .clkIn (clkIn),
        .rst_n (rst_n),
        .key_n (keyPage_n),
        .press (page_press)
    );

`ifdef SM_BOARD_STEP_EN
    typedef enum logic {ST_STEP = 1'b0, ST_RUN = 1'b1} mode_t;
    mode_t state;
    logic  step_press;

    sm_board_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_mode_key (
        .clkIn (clkIn),
        .rst_n (rst_n),
        .key_n (keyMode_n),
        .press (mode_press)
    );

    sm_board_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_step_key (
        .clkIn (clkIn),
        .rst_n (rst_n),
        .key_n (keyStep_n),
        .press (step_press)
    );

    // Mode FSM: each mode press toggles RUN/STEP.
    always_ff @(posedge clkIn) begin
        if (!rst_n)
            state <= ST_STEP;
        else if (mode_press)
            state <= (state == ST_RUN) ? ST_STEP : ST_RUN;
    end

    assign running   = (state == ST_RUN);
    assign run_entry = mode_press && (state == ST_STEP);
    // A mode change in the same cycle swallows the step.
    assign step_fire = step_press && (state == ST_STEP) && !mode_press;
`else
    logic unused_keys;
    assign unused_keys = keyMode_n ^ keyStep_n;
    assign mode_press  = 1'b0;
    assign running     = 1'b1;
    assign run_entry   = 1'b0;
    assign step_fire   = 1'b0;
`endif

    assign mask = (16'd1 << clkDivide) - 16'd1;

    // Enable source: divider match in RUN, a step press in STEP.
    always_comb begin
        en_next = 1'b0;
        if (running && !mode_press)
            en_next = ((cnt & mask) == mask);
        else if (step_fire)
            en_next = 1'b1;
    end

    // Divider counter, enable pulse and heartbeat; counter frozen outside RUN.
    always_ff @(posedge clkIn) begin
        if (!rst_n) begin
            cnt      <= '0;
            cpuClkEn <= 1'b0;
            hb       <= 1'b0;
        end else begin
            if (run_entry)
                cnt <= '0;
            else if (running && !mode_press)
                cnt <= cnt + 16'd1;
            cpuClkEn <= en_next;
            if (en_next)
                hb <= ~hb;
        end
    end

    assign shamt   = 16'(page) * 16'(LED_W - 1);
    assign shifted = {{(LED_W-1){1'b0}}, regData} >> shamt;

    // Switch sync, page selection (address change wins) and display register.
    always_ff @(posedge clkIn) begin
        if (!rst_n) begin
            sw_s1   <= '0;
            regAddr <= '0;
            page    <= '0;
            led_hi  <= '0;
        end else begin
            sw_s1   <= sw;
            regAddr <= 5'(sw_s1);
            if (sw_s1 != regAddr[SW_W-1:0])
                page <= '0;
            else if (page_press)
                page <= (page == PW'(PAGES - 1)) ? '0 : page + 1'b1;
            led_hi <= shifted[LED_W-2:0];
        end
    end

    assign led = {led_hi, hb};
endmodule

// File: tb/tb_sm_board_ctrl.sv
// Randomized + directed bench for sm_board_ctrl with a behavioural model and
// a pulse scoreboard. Works with and without SM_BOARD_STEP_EN.
module tb_sm_board_ctrl;
    localparam int LED_W = 8;
    localparam int SW_W  = 4;
    localparam int DEB   = 4;
    localparam int PAGES = (32 + LED_W - 2) / (LED_W - 1);
`ifdef SM_BOARD_STEP_EN
    localparam bit STEP_EN = 1'b1;
`else
    localparam bit STEP_EN = 1'b0;
`endif

    logic clkIn = 1'b0;
    logic rst_n = 1'b0;
    logic keyMode_n = 1'b1, keyStep_n = 1'b1, keyPage_n = 1'b1;
    logic [SW_W-1:0] sw = '0;
    logic [3:0] clkDivide = 4'd15;
    logic [31:0] regData = '0;
    logic [4:0] regAddr;
    logic cpuClkEn, running;
    logic [LED_W-1:0] led;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    always #5 clkIn = ~clkIn;

    sm_board_ctrl #(.LED_W(LED_W), .SW_W(SW_W), .DEBOUNCE_CYCLES(DEB)) dut (
        .clkIn(clkIn), .rst_n(rst_n), .keyMode_n(keyMode_n), .keyStep_n(keyStep_n),
        .keyPage_n(keyPage_n), .sw(sw), .clkDivide(clkDivide), .regData(regData),
        .regAddr(regAddr), .cpuClkEn(cpuClkEn), .running(running), .led(led)
    );

    // ---------------- reference model (evaluated on each rising edge) -------------
    bit k_dly[3][$];          // two-sample delay through the synchronizer
    bit k_stable[3];
    int k_run[3];
    bit k_press[3];           // 0 = mode, 1 = step, 2 = page
    bit m_run, m_en, m_hb, armed;
    int m_k;                  // rising edges spent in RUN since entry
    int m_page;
    logic [4:0] m_addr;
    logic [SW_W-1:0] m_sw1;
    logic [LED_W-2:0] m_ledhi;
    int exp_q[$];             // expected cpuClkEn cycle numbers

    always @(posedge clkIn) begin
        bit raw[3];
        bit pr[3];
        bit d;
        int old_page;
        longint sh;
        cyc++;
        raw[0] = keyMode_n; raw[1] = keyStep_n; raw[2] = keyPage_n;
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                k_dly[i] = '{1'b1, 1'b1};
                k_stable[i] = 1'b1; k_run[i] = 0; k_press[i] = 1'b0;
            end
            m_run = !STEP_EN; m_en = 0; m_hb = 0; m_k = 0; m_page = 0;
            m_addr = '0; m_sw1 = '0; m_ledhi = '0; armed = 1'b1;
        end else begin
            pr = k_press;
            for (int i = 0; i < 3; i++) begin
                d = k_dly[i].pop_front();
                k_dly[i].push_back(raw[i]);
                k_press[i] = 1'b0;
                if (d != k_stable[i]) begin
                    k_run[i]++;
                    if (k_run[i] == DEB) begin
                        k_stable[i] = d; k_run[i] = 0; k_press[i] = (d == 1'b0);
                    end
                end else k_run[i] = 0;
            end
            if (!STEP_EN) begin pr[0] = 1'b0; pr[1] = 1'b0; end
            m_en = 1'b0;
            if (m_run && !pr[0]) begin
                m_k++;
                m_en = (m_k % (1 << clkDivide)) == 0;
            end else if (!m_run && pr[1] && !pr[0]) m_en = 1'b1;
            if (pr[0]) begin m_run = !m_run; m_k = 0; end
            if (m_en) begin m_hb = !m_hb; exp_q.push_back(cyc); end
            old_page = m_page;
            if (5'(m_sw1) != m_addr) m_page = 0;
            else if (pr[2]) m_page = (m_page + 1) % PAGES;
            m_addr = 5'(m_sw1);
            m_sw1 = sw;
            sh = longint'(regData) >> (old_page * (LED_W - 1));
            m_ledhi = sh[LED_W-2:0];
        end
    end

    // ---------------- monitor / scoreboard --------------------------------------
    always @(negedge clkIn) begin
        if (armed) begin
            if (cpuClkEn === 1'b1) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL pulse: unexpected cpuClkEn at cycle %0d", cyc);
                end else begin
                    int e;
                    e = exp_q.pop_front();
                    if (e != cyc) begin
                        bad++;
                        $display("FAIL pulse: cpuClkEn at cycle %0d, required at %0d", cyc, e);
                    end
                end
            end
            while (exp_q.size() > 0 && exp_q[0] < cyc) begin
                total++; bad++;
                $display("FAIL pulse: missing cpuClkEn required at cycle %0d", exp_q[0]);
                void'(exp_q.pop_front());
            end
            total++;
            if ({running, regAddr, led} !== {m_run, m_addr, m_ledhi, m_hb}) begin
                bad++;
                $display("FAIL state @%0d: run=%b addr=%h led=%h, required run=%b addr=%h led=%h",
                         cyc, running, regAddr, led, m_run, m_addr, {m_ledhi, m_hb});
            end
        end
    end

    // ---------------- stimulus helpers ------------------------------------------
    task automatic tick(input int n);
        repeat (n) @(negedge clkIn);
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h, required %h", nm, act, req);
        end
    endtask

    task automatic page_press();
        keyPage_n = 1'b0; tick(10);
        keyPage_n = 1'b1; tick(10);
    endtask

    task automatic wait_running(input logic lvl, output int pulses);
        int w;
        pulses = 0;
        for (w = 0; w < 20 && running !== lvl; w++) begin
            tick(1);
            if (cpuClkEn === 1'b1) pulses++;
        end
        check("wait_running", {31'd0, running}, {31'd0, lvl});
    endtask

    logic [6:0] page_tbl [6] = '{7'h6F, 7'h7D, 7'h36, 7'h75, 7'h0D, 7'h6F};

    initial begin
        int np;
        logic hb0;
        logic [31:0] pm;

        // Reset values
        tick(3);
        check("reset_en", {31'd0, cpuClkEn}, 32'd0);
        check("reset_led", {24'd0, led}, 32'd0);
        check("reset_addr", {27'd0, regAddr}, 32'd0);
        check("reset_running", {31'd0, running}, {31'd0, STEP_EN ? 1'b0 : 1'b1});
        rst_n = 1'b1;

        // Paging through 0xDEADBEEF with wrap
        regData = 32'hDEADBEEF;
        tick(4);
        check("page0", {25'd0, led[7:1]}, {25'd0, page_tbl[0]});
        for (int i = 1; i < 6; i++) begin
            page_press();
            check("page_step", {25'd0, led[7:1]}, {25'd0, page_tbl[i]});
        end
        page_press(); page_press();
        check("page2", {25'd0, led[7:1]}, 32'h36);
        sw = 4'd3; tick(4);
        check("addr_change", {27'd0, regAddr}, 32'd3);
        check("addr_page_clear", {25'd0, led[7:1]}, 32'h6F);
        sw = 4'd5; tick(1);
        check("sw_lat1", {27'd0, regAddr}, 32'd3);
        tick(1);
        check("sw_lat2", {27'd0, regAddr}, 32'd5);
        tick(2);
        regData = 32'h12; tick(1);
        check("data_lat", {25'd0, led[7:1]}, 32'h12);

`ifdef SM_BOARD_STEP_EN
        // Glitchy step key: exactly one pulse 7 cycles after the final fall
        keyStep_n = 1'b0; tick(3); keyStep_n = 1'b1; tick(1); keyStep_n = 1'b0;
        np = 0; pm = 0;
        for (int j = 1; j <= 12; j++) begin
            tick(1);
            if (cpuClkEn === 1'b1) begin np++; pm = j; end
        end
        check("step_count", np, 1);
        check("step_time", pm, 7);
        keyStep_n = 1'b1; tick(10);

        // Enter RUN with clkDivide = 3: pulses at 8, 16, 24
        clkDivide = 4'd3;
        keyMode_n = 1'b0;
        wait_running(1'b1, np);
        keyMode_n = 1'b1;
        hb0 = led[0]; pm = 0;
        for (int j = 1; j <= 24; j++) begin
            tick(1);
            if (cpuClkEn === 1'b1) pm[j] = 1'b1;
        end
        check("run_pulses", pm, (32'd1 << 8) | (32'd1 << 16) | (32'd1 << 24));
        check("heartbeat", {31'd0, led[0]}, {31'd0, ~hb0});

        // Back to STEP, then simultaneous mode+step press
        keyMode_n = 1'b0; wait_running(1'b0, np); keyMode_n = 1'b1; tick(10);
        keyMode_n = 1'b0; keyStep_n = 1'b0;
        wait_running(1'b1, np);
        tick(2); if (cpuClkEn === 1'b1) np++;
        check("simul_no_step", np, 0);
        keyMode_n = 1'b1; keyStep_n = 1'b1; tick(10);
`else
        // Divider every cycle; mode/step keys ignored
        clkDivide = 4'd0; tick(2);
        np = 0;
        for (int j = 0; j < 10; j++) begin tick(1); if (cpuClkEn === 1'b1) np++; end
        check("div0_pulses", np, 10);
        keyMode_n = 1'b0; keyStep_n = 1'b0; np = 0;
        for (int j = 0; j < 10; j++) begin tick(1); if (cpuClkEn === 1'b1) np++; end
        check("keys_ignored_pulses", np, 10);
        check("keys_ignored_run", {31'd0, running}, 32'd1);
        keyMode_n = 1'b1; keyStep_n = 1'b1; clkDivide = 4'd3; tick(10);
`endif

        // Reset mid-count and mid-debounce
        keyPage_n = 1'b0; tick(3);
        rst_n = 1'b0; keyPage_n = 1'b1; tick(1);
        check("rst_en", {31'd0, cpuClkEn}, 32'd0);
        check("rst_led", {24'd0, led}, 32'd0);
        check("rst_addr", {27'd0, regAddr}, 32'd0);
        check("rst_running", {31'd0, running}, {31'd0, STEP_EN ? 1'b0 : 1'b1});
        rst_n = 1'b1; np = 0;
        for (int j = 0; j < 12; j++) begin tick(1); if (cpuClkEn === 1'b1) np++; end
        check("rst_no_stray", np, STEP_EN ? 0 : 1);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 7) == 0) keyMode_n = ~keyMode_n;
            if ($urandom_range(0, 5) == 0) keyStep_n = ~keyStep_n;
            if ($urandom_range(0, 6) == 0) keyPage_n = ~keyPage_n;
            if ($urandom_range(0, 49) == 0) sw = SW_W'($urandom);
            if ($urandom_range(0, 99) == 0) clkDivide = 4'($urandom_range(0, 5));
            regData = $urandom;
            rst_n = ($urandom_range(0, 399) != 0);
            tick(1);
        end
        rst_n = 1'b1; keyMode_n = 1'b1; keyStep_n = 1'b1; keyPage_n = 1'b1;
        tick(40);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
